pipe_skid_stage: RTL and testbench
==================================

// Module: pipe_skid_stage
// PURPOSE
//  Elastic pipeline stage placed directly upstream of the FF pipeline registers.
//  Carries a SIZE-bit payload between two processor stages with a valid/ready handshake.
//  A two-entry skid buffer gives full throughput with a registered in_ready.
//  A downstream stall therefore never forms a combinational path back to the producer.
//  flush discards all in-flight data, for branch mispredict and exceptions.
// PARAMETERS
//  SIZE  32  payload width in bits (minimum 1)
// PORTS
//  clk        in   1     rising-edge clock; the only clock
//  reset      in   1     synchronous, active-high reset
//  flush      in   1     synchronous drop of all buffered entries
//  in_valid   in   1     producer presents a payload on in
//  in_ready   out  1     stage can accept; depends on state only (registered)
//  in         in   SIZE  producer payload
//  out_valid  out  1     out holds a valid payload
//  out_ready  in   1     consumer takes out this cycle
//  out        out  SIZE  payload to consumer, driven from the main register
//  count      out  2     occupancy 0..2
// BEHAVIOUR
//  Handshake terms
//   - accept = in_valid & in_ready.
//   - pop = out_valid & out_ready.
//   - A transfer occurs only at a rising clk edge.
//  Storage and state
//   - Two registers: main (drives out) and skid.
//   - State is EMPTY, ONE or FULL.
//   - count is 0/1/2 respectively.
//   - out_valid = (state != EMPTY).
//   - in_ready = (state != FULL).
//  Reset (highest priority)
//   - Next state EMPTY; main=0; skid=0.
//   - After reset: out=0, out_valid=0, in_ready=1, count=0.
//  Flush (below reset)
//   - Next state EMPTY.
//   - The same-cycle accept and pop are ignored.
//   - main and skid keep their values; out is don't-care while out_valid=0.
//  Transitions (no reset, no flush)
//   - EMPTY: accept -> main<=in, ONE.
//   - ONE: accept & !pop -> skid<=in, FULL.
//   - ONE: accept & pop -> main<=in, stay ONE.
//   - ONE: !accept & pop -> EMPTY.
//   - ONE: neither -> stay ONE.
//   - FULL: pop -> main<=skid, ONE (in_ready=0, so no accept).
//   - FULL: !pop -> stay FULL.
//  Timing
//   - Latency: a payload accepted at edge N is on out with out_valid=1 after edge N.
//   - Throughput: 1 payload/cycle sustained while out_ready=1.
//  Ordering and stability
//   - Strict FIFO order; no payload is duplicated or lost except by flush/reset.
//   - out stays stable while out_valid=1 and out_ready=0.
//   - out_ready while EMPTY has no effect.
//   - in_valid while FULL has no effect; the producer must hold its payload.
// TESTING
//  1. reset=1 for 2 cycles -> out_valid=0, in_ready=1, count=0, out=0.
//  2. in=5,7,9 on consecutive cycles, out_ready=1 -> out=5,7,9 one cycle later each; count stays 1.
//  3. out_ready=0, push 0xA then 0xB -> count=2, in_ready=0.
//     Then a third push of 0xC is not accepted.
//     Then out_ready=1 -> out=0xA, then 0xB; in_ready returns to 1.
//  4. FULL with 0x1,0x2, assert flush together with in_valid (in=0x3) -> next cycle count=0, out_valid=0.
//     0x3 is never delivered.
//  5. ONE holding 0x4, accept 0x5 and pop in the same cycle -> out=0x5, count=1.
//  6. reset asserted while FULL -> next cycle count=0, out=0; next accepted payload is delivered first.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline stage with a two-entry skid buffer.
// in_ready is decoded from the state register only, so a consumer stall never reaches the producer combinationally.
module pipe_skid_stage #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out,
  output logic [1:0]      count
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic   [SIZE-1:0] main;
  logic   [SIZE-1:0] skid;
  logic              accept;
  logic              pop;

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign count     = state;
  assign out       = main;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      main  <= '0;
      skid  <= '0;
    end else if (flush) begin
      // Payload registers keep stale data; out_valid=0 hides it.
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main  <= in;
            state <= ONE;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            skid  <= in;
            state <= FULL;
          end else if (accept && pop) begin
            main  <= in;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main  <= skid;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage; expected values are hand-computed per step.
module tb_pipe_skid_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic [1:0]  count;

  int assertCount;
  int failCount;

  pipe_skid_stage #(.SIZE(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Checks the handshake/occupancy outputs; payload only when the step defines it.
  task automatic checkState(input string tag, input logic expValid, input logic expReady,
                            input logic [1:0] expCount, input logic checkData, input logic [31:0] expOut);
    checkOutput({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, expValid});
    checkOutput({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, expReady});
    checkOutput({tag, ".count"}, {30'd0, count}, {30'd0, expCount});
    if (checkData)
      checkOutput({tag, ".out"}, dout, expOut);
  endtask

  // Drives one cycle of inputs, waits for the edge, then lets outputs settle.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r, input logic f);
    in_valid  = v;
    din       = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    din         = '0;
    out_ready   = 1'b0;

    // Reset for two cycles
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkState("reset", 1'b0, 1'b1, 2'd0, 1'b1, 32'h0);
    reset = 1'b0;

    // Streaming 5,7,9 with the consumer always ready
    applyStimulus(1'b1, 32'h5, 1'b1, 1'b0);
    checkState("stream5", 1'b1, 1'b1, 2'd1, 1'b1, 32'h5);
    applyStimulus(1'b1, 32'h7, 1'b1, 1'b0);
    checkState("stream7", 1'b1, 1'b1, 2'd1, 1'b1, 32'h7);
    applyStimulus(1'b1, 32'h9, 1'b1, 1'b0);
    checkState("stream9", 1'b1, 1'b1, 2'd1, 1'b1, 32'h9);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkState("drain", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);

    // Stall, fill, reject third push, then drain in order
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
    checkState("fillA", 1'b1, 1'b1, 2'd1, 1'b1, 32'hA);
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
    checkState("fillB", 1'b1, 1'b0, 2'd2, 1'b1, 32'hA);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);
    checkState("rejectC", 1'b1, 1'b0, 2'd2, 1'b1, 32'hA);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkState("popA", 1'b1, 1'b1, 2'd1, 1'b1, 32'hB);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkState("popB", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);

    // Flush while full, with a simultaneous push of 3
    applyStimulus(1'b1, 32'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h2, 1'b0, 1'b0);
    checkState("full12", 1'b1, 1'b0, 2'd2, 1'b1, 32'h1);
    applyStimulus(1'b1, 32'h3, 1'b0, 1'b1);
    checkState("flush", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkState("noThree", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);

    // Accept and pop in the same cycle while holding one entry
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0);
    checkState("hold4", 1'b1, 1'b1, 2'd1, 1'b1, 32'h4);
    applyStimulus(1'b1, 32'h5, 1'b1, 1'b0);
    checkState("swap5", 1'b1, 1'b1, 2'd1, 1'b1, 32'h5);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkState("pop5", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);

    // Reset while full, then the next payload comes out first
    applyStimulus(1'b1, 32'h6, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7, 1'b0, 1'b0);
    checkState("full67", 1'b1, 1'b0, 2'd2, 1'b1, 32'h6);
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkState("resetFull", 1'b0, 1'b1, 2'd0, 1'b1, 32'h0);
    reset = 1'b0;
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
    checkState("after8", 1'b1, 1'b1, 2'd1, 1'b1, 32'h8);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkState("pop8", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
